// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: power-of-two ring buffer of {pc, inst} entries with flush.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; entries are only observed while count says they are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited sequential fetch with redirect and stale-response discard.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(QDEPTH + 1);

  // Handshakes: a transfer happens in a cycle where valid && ready are both high at the
  // rising edge; valid never depends on ready. Responses have no ready and are taken as offered.

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  rsp_entry;
  logic          issue;
  logic          rsp_acc;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          fifo_push;
  logic          pop;
  logic [31:0]   redirect_aligned;
  logic          unused_bits;

  assign unused_bits      = ^redirect_pc[1:0];
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Queue slots already claimed: resident entries plus in-flight requests that will be kept.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, discard};

  assign imem_req_valid = !reset && !redirect_valid
                          && (outstanding < CW'(QDEPTH))
                          && (credit_used < (CW + 1)'(QDEPTH));
  assign imem_req_addr  = fetch_pc;

  assign issue     = imem_req_valid && imem_req_ready;
  assign rsp_acc   = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop  = rsp_acc && (discard != '0);
  assign rsp_keep  = rsp_acc && (discard == '0);
  assign fifo_push = rsp_keep && !redirect_valid && !fifo_full;
  assign pop       = inst_valid && inst_ready;
  assign rsp_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(rsp_acc);
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        // Everything still in flight after this cycle belongs to the old path.
        discard  <= outstanding - CW'(rsp_acc);
      end else begin
        if (issue)    fetch_pc <= fetch_pc + PC_INC;
        if (rsp_keep) rsp_pc   <= rsp_pc + PC_INC;
        if (rsp_drop) discard  <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (rsp_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  assign inst_valid = !fifo_empty;
  assign inst_data  = inst_valid ? fifo_head.inst : '0;
  assign inst_pc    = inst_valid ? fifo_head.pc   : '0;

endmodule
